mips_ctrl_fsm: RTL
==================

Name: mips_ctrl_fsm

Overview:
Multi-cycle control unit that produces every control signal the datapath consumes.
- Consumes: instruction word from the fetch unit, Zero from the datapath.
- Drives: RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg, Branch, Jump, plus PC/IR enables for the fetch unit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB so register-file and memory writes happen in exactly one clock per instruction.
- Replaces hand-driven control stimulus as the datapath's source of control.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 1: 1 = an unknown opcode/funct enters HALT; 0 = it retires as a NOP.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  fetch unit presents a valid word on Instructions.
- Instructions  in  32  instruction word from the fetch unit.
- Zero  in  1  ALU zero flag from the datapath.
- ir_ld  out  1  latch Instructions into the internal IR.
- pc_en  out  1  fetch unit advances the PC (PC+4, branch or jump) this cycle.
- RegDst  out  1  1 = rd is the write destination, 0 = rt.
- RegWr  out  1  register file write strobe.
- ALUsrc  out  1  1 = sign-extended immediate, 0 = Rt data.
- ALUcntrl  out  2  ALU op: 00 add, 01 sub, 10 and, 11 or.
- MemWr  out  1  data memory write strobe.
- MemToReg  out  1  1 = writeback from memory, 0 = from ALU.
- Branch  out  1  beq in EXEC; the fetch unit takes the branch when Branch & Zero.
- Jump  out  1  j in EXEC.
- busy  out  1  high in every state except FETCH and HALT.
- illegal  out  1  sticky; set on entry to HALT.
- retired  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W.

Behaviour:
- Reset: state = FETCH. IR, retired, illegal and all control outputs go to 0.
- rst asserted mid-instruction aborts the instruction immediately; no RegWr or MemWr pulse is issued afterwards.
- FETCH:
  - Waits while instr_valid = 0.
  - When instr_valid = 1: ir_ld = 1, the IR loads on that edge, next state is DECODE.
- DECODE:
  - Decodes IR[31:26]; for R-type also decodes funct IR[5:0].
  - The static controls (RegDst, ALUsrc, ALUcntrl, MemToReg) become valid at the end of this cycle.
  - They are held constant until the cycle after the instruction retires, then cleared to 0.
- Decode table (op / funct -> RegDst ALUsrc ALUcntrl MemToReg, path):
  - 000000 / 100000 add: 1 0 00 0, E-W.
  - 000000 / 100010 sub: 1 0 01 0, E-W.
  - 000000 / 100100 and: 1 0 10 0, E-W.
  - 000000 / 100101 or: 1 0 11 0, E-W.
  - 001000 addi: 0 1 00 0, E-W.
  - 100011 lw: 0 1 00 1, E-M-W.
  - 101011 sw: 0 1 00 0, E-M.
  - 000100 beq: ALUsrc 0, ALUcntrl 01, E only.
  - 000010 j: E only.
- EXEC:
  - ALU evaluates.
  - beq: Branch = 1 and pc_en = 1 for this cycle; retire; next state FETCH.
  - j: Jump = 1 and pc_en = 1; retire; next state FETCH.
  - All other instructions go to MEM (lw/sw) or WB.
- MEM:
  - sw: MemWr = 1 for exactly one cycle, pc_en = 1, retire; next state FETCH.
  - lw: next state WB.
- WB: RegWr = 1 for exactly one cycle, pc_en = 1, retire; next state FETCH.
- Latency, FETCH-accept cycle to retire:
  - R-type / addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq / j: 3 cycles.
- Retire: exactly one pc_en pulse per instruction; retired increments on that same edge.
- Illegal op/funct:
  - HALT_ON_ILLEGAL = 1: DECODE -> HALT. illegal = 1, all strobes 0, pc_en 0. HALT is left only by rst.
  - HALT_ON_ILLEGAL = 0: DECODE asserts pc_en, retires, next state FETCH. No writes occur.
- Strobe exclusivity: RegWr, MemWr, Branch and Jump are never high in the same cycle.
- instr_valid is ignored outside FETCH.
- X on Instructions outside FETCH must not propagate to any output.

Decomposition:
- Package mips_pkg holds:
  - typedef state_t {FETCH, DECODE, EXEC, MEM, WB, HALT}.
  - Opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J.
  - Funct constants FN_ADD, FN_SUB, FN_AND, FN_OR.
  - ALU op constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR.
- One sub-module, mips_ctrl_decode: purely combinational map from IR to static controls plus an illegal flag.
- The FSM, IR and counter stay in mips_ctrl_fsm.

Test Plan:
- addi $1,$0,2015 (0x200107DF) with instr_valid:
  - ir_ld in cycle 0, ALUsrc = 1 and RegDst = 0 from cycle 2.
  - RegWr and pc_en both high only in cycle 3; retired = 1.
- add $1,$1,$2 (0x00220820):
  - RegDst = 1, ALUsrc = 0, ALUcntrl = 00.
  - Single RegWr pulse in cycle 3; MemWr never high.
- sw $2,0($0) (0xAC020000) then lw $3,0($0) (0x8C030000):
  - sw: MemWr pulse in cycle 3, no RegWr.
  - lw: MemToReg = 1 and RegWr pulse in cycle 4; retired = 2.
- beq $1,$1,+4 (0x10210004), run once with Zero = 1 and once with Zero = 0:
  - Branch and pc_en high in cycle 2 in both runs.
  - No RegWr or MemWr in either run.
- Opcode 0x3F:
  - HALT_ON_ILLEGAL = 1: illegal = 1 from cycle 2, no strobes for 20 cycles, rst clears it.
  - HALT_ON_ILLEGAL = 0: pc_en in cycle 1, retired increments.
- rst asserted during the lw MEM cycle:
  - All outputs go to 0 asynchronously, no RegWr follows, state returns to FETCH.
  - The next addi completes normally with retired = 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
// Contents: FSM state type, instruction class type, static control bundle,
// opcode / funct / ALU-op constants.
package mips_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    // Execution path taken after DECODE
    typedef enum logic [2:0] {CL_ALU, CL_LW, CL_SW, CL_BEQ, CL_J} iclass_t;

    // Controls that stay constant for the life of one instruction
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_cntrl;
        logic       mem_to_reg;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction decoder: maps the IR to the static controls,
// the execution-path class and an illegal flag.
// Ports:
//   ir      in   32  latched instruction word
//   ctrl    out  5   static controls (RegDst, ALUsrc, ALUcntrl, MemToReg)
//   iclass  out  3   execution path class
//   bad     out  1   unknown opcode or R-type funct
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [31:0] ir,
    output ctrl_t       ctrl,
    output iclass_t     iclass,
    output logic        bad
);

    // Register/immediate fields are consumed by the datapath, not here
    logic [19:0] unused_ir;
    assign unused_ir = ir[25:6];

    always_comb begin
        ctrl   = '0;
        iclass = CL_J;
        bad    = 1'b0;
        case (ir[31:26])
            OP_RTYPE: begin
                iclass       = CL_ALU;
                ctrl.reg_dst = 1'b1;
                case (ir[5:0])
                    FN_ADD:  ctrl.alu_cntrl = ALU_ADD;
                    FN_SUB:  ctrl.alu_cntrl = ALU_SUB;
                    FN_AND:  ctrl.alu_cntrl = ALU_AND;
                    FN_OR:   ctrl.alu_cntrl = ALU_OR;
                    default: begin
                        bad  = 1'b1;
                        ctrl = '0;
                    end
                endcase
            end
            OP_ADDI: begin
                iclass       = CL_ALU;
                ctrl.alu_src = 1'b1;
            end
            OP_LW: begin
                iclass          = CL_LW;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                iclass       = CL_SW;
                ctrl.alu_src = 1'b1;
            end
            OP_BEQ: begin
                iclass         = CL_BEQ;
                ctrl.alu_cntrl = ALU_SUB;
            end
            OP_J:    iclass = CL_J;
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives every datapath control signal.
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   instr_valid       fetch unit presents a valid word (sampled in FETCH only)
//   Instructions      instruction word from the fetch unit
//   Zero              ALU zero flag (the fetch unit combines it with Branch)
//   ir_ld, pc_en      IR load / PC advance enables for the fetch unit
//   RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg, Branch, Jump
//                     datapath controls
//   busy              instruction in flight
//   illegal           sticky, set on entry to HALT
//   retired           retired-instruction count, wraps
module mips_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W           = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      Instructions,
    input  logic             Zero,
    output logic             ir_ld,
    output logic             pc_en,
    output logic             RegDst,
    output logic             RegWr,
    output logic             ALUsrc,
    output logic [1:0]       ALUcntrl,
    output logic             MemWr,
    output logic             MemToReg,
    output logic             Branch,
    output logic             Jump,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    // Branch resolution (Branch & Zero) happens in the fetch unit
    logic unused_zero;
    assign unused_zero = Zero;

    state_t           state_q, state_d;
    logic [31:0]      ir_q;
    ctrl_t            ctrl_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    ctrl_t   dec_ctrl;
    iclass_t dec_class;
    logic    dec_bad;
    logic    ctrl_ld;

    mips_ctrl_decode u_decode (
        .ir     (ir_q),
        .ctrl   (dec_ctrl),
        .iclass (dec_class),
        .bad    (dec_bad)
    );

    always_comb begin
        state_d = state_q;
        ir_ld   = 1'b0;
        pc_en   = 1'b0;
        RegWr   = 1'b0;
        MemWr   = 1'b0;
        Branch  = 1'b0;
        Jump    = 1'b0;
        ctrl_ld = 1'b0;
        case (state_q)
            FETCH: begin
                // Gate with rst so every output reads 0 while reset is held
                if (instr_valid && !rst) begin
                    ir_ld   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dec_bad) begin
                    if (HALT_ON_ILLEGAL) begin
                        state_d = HALT;
                    end else begin
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end
                end else begin
                    ctrl_ld = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (dec_class)
                    CL_BEQ: begin
                        Branch  = 1'b1;
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end
                    CL_J: begin
                        Jump    = 1'b1;
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end
                    CL_LW, CL_SW: state_d = MEM;
                    default:      state_d = WB;
                endcase
            end
            MEM: begin
                if (dec_class == CL_SW) begin
                    MemWr   = 1'b1;
                    pc_en   = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            WB: begin
                RegWr   = 1'b1;
                pc_en   = 1'b1;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (ir_ld) begin
                ir_q <= Instructions;
            end
            // Static controls live from EXEC through the retire cycle
            if (ctrl_ld) begin
                ctrl_q <= dec_ctrl;
            end else if (pc_en) begin
                ctrl_q <= '0;
            end
            if (state_d == HALT) begin
                illegal_q <= 1'b1;
            end
            if (pc_en) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign RegDst   = ctrl_q.reg_dst;
    assign ALUsrc   = ctrl_q.alu_src;
    assign ALUcntrl = ctrl_q.alu_cntrl;
    assign MemToReg = ctrl_q.mem_to_reg;
    assign busy     = (state_q != FETCH) && (state_q != HALT);
    assign illegal  = illegal_q;
    assign retired  = retired_q;

endmodule
